bcd_capture_datapath: RTL and testbench

Datapath stage directly downstream of the number-conversion controller. It consumes the controller strobes (read_data, store_num, en_c, write_file) and returns the running count cnt that the controller tests for loop exit. Each sampled binary word is converted to packed BCD and stored in an on-chip buffer. On write_file the buffer is drained over a valid/ready stream to the file-writer/testbench sink.

---
 rtl/bcd_capture_datapath.sv | 122 ++++++++++++
 tb/tb_bcd_capture_datapath.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_capture_datapath.sv
// Samples binary words, converts them to packed BCD and buffers them,
// then drains the buffer over a valid/ready stream on write_file.
module bcd_capture_datapath #(
  parameter int DATA_W = 16,
  parameter int DIGITS = 5,
  parameter int DEPTH  = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  read_data,
  input  logic                  store_num,
  input  logic                  en_c,
  input  logic                  write_file,
  output logic [31:0]           cnt,
  output logic [4*DIGITS-1:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  overflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_VALID = 2'd2;

  logic [DATA_W-1:0]   in_reg;
  logic [4*DIGITS-1:0] conv_reg;
  logic [4*DIGITS-1:0] bcd;
  logic [4*DIGITS-1:0] mem [DEPTH];
  logic [CW-1:0]       wr_count;
  logic [CW-1:0]       rd_ptr;
  logic [1:0]          state;
  logic                do_write;

  // Double-dabble: add 3 to any digit >4, then shift in the next bit.
  always_comb begin
    bcd = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (bcd[4*d +: 4] > 4'd4)
          bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end
      bcd = {bcd[4*DIGITS-2:0], in_reg[i]};
    end
  end

  assign do_write = store_num && (state == S_IDLE)
                 && (wr_count < DEPTH_C);

  always_ff @(posedge clk) begin
    if (do_write)
      mem[wr_count] <= conv_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_reg   <= '0;
      conv_reg <= '0;
      cnt      <= '0;
      wr_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (read_data)
        in_reg <= in_data;
      conv_reg <= bcd;
      if (en_c && (cnt != 32'hFFFF_FFFF))
        cnt <= cnt + 32'd1;
      if (do_write)
        wr_count <= wr_count + ONE_C;
      else if (store_num)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rd_ptr    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (write_file && (wr_count != '0)) begin
            rd_ptr <= '0;
            busy   <= 1'b1;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          out_data  <= mem[rd_ptr];
          out_last  <= (rd_ptr == wr_count - ONE_C);
          out_valid <= 1'b1;
          state     <= S_VALID;
        end
        S_VALID: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              out_last <= 1'b0;
              busy     <= 1'b0;
              state    <= S_IDLE;
            end else begin
              rd_ptr <= rd_ptr + ONE_C;
              state  <= S_LOAD;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_capture_datapath.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor
// pops and compares every accepted beat.
module tb_bcd_capture_datapath;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_data = '0;
  logic        read_data = 1'b0;
  logic        store_num = 1'b0;
  logic        en_c = 1'b0;
  logic        write_file = 1'b0;
  logic [31:0] cnt;
  logic [19:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        busy;
  logic        overflow;

  int errors = 0;
  int checks = 0;
  int beats  = 0;

  logic [20:0] sb_q [$];
  logic [19:0] exp_buf [25];
  int          exp_wr  = 0;
  logic [31:0] exp_cnt = 0;
  logic        exp_ovf = 1'b0;

  always #5 clk = ~clk;

  bcd_capture_datapath dut (
    .clk(clk), .rst(rst), .in_data(in_data),
    .read_data(read_data), .store_num(store_num),
    .en_c(en_c), .write_file(write_file), .cnt(cnt),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .overflow(overflow)
  );

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      logic [20:0] e;
      checks++;
      beats++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL beat: unexpected data=%h last=%0b",
                 out_data, out_last);
      end else begin
        e = sb_q.pop_front();
        if ({out_last, out_data} !== e) begin
          errors++;
          $display("FAIL beat%0d: got last=%0b data=%h want last=%0b data=%h",
                   beats, out_last, out_data, e[20], e[19:0]);
        end
      end
    end
  end

  function automatic logic [19:0] bcd_ref(input int v);
    logic [19:0] r;
    int x;
    r = '0;
    x = v;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [15:0] v, input logic [19:0] e,
                       input bit inc);
    in_data = v;
    read_data = 1'b1;
    tick();
    read_data = 1'b0;
    tick();
    store_num = 1'b1;
    tick();
    store_num = 1'b0;
    if (exp_wr < 25) begin
      exp_buf[exp_wr] = e;
      exp_wr++;
    end else begin
      exp_ovf = 1'b1;
    end
    if (inc) begin
      en_c = 1'b1;
      tick();
      en_c = 1'b0;
      exp_cnt++;
    end
  endtask

  task automatic start_drain();
    write_file = 1'b1;
    for (int i = 0; i < exp_wr; i++)
      sb_q.push_back({(i == exp_wr - 1), exp_buf[i]});
    tick();
    write_file = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      if (!busy) return;
      tick();
    end
    chk("drain_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    exp_wr = 0;
    exp_cnt = 0;
    exp_ovf = 1'b0;
    sb_q.delete();
    tick();
  endtask

  initial begin
    int b0;
    bit ok;
    logic [19:0] hd;
    logic hl;

    // 1: reset state, then async reset after activity
    #12;
    chk("rst_cnt", cnt, 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    tick();
    store(16'd77, 20'h00077, 1'b1);
    chk("pre_cnt", cnt, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_cnt", cnt, 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_last", 32'(out_last), 32'd0);
    do_reset();

    // 2: single sample
    store(16'd12345, 20'h12345, 1'b1);
    chk("t2_cnt", cnt, exp_cnt);
    b0 = beats;
    start_drain();
    wait_idle();
    chk("t2_beats", beats - b0, 32'd1);
    chk("t2_busy", 32'(busy), 32'd0);
    do_reset();

    // 3: 25-iteration controller loop
    for (int k = 0; k < 25; k++)
      store(16'(k * 2621), bcd_ref(k * 2621), 1'b1);
    chk("t3_k24", 32'(exp_buf[24]), 32'h62904);
    chk("t3_cnt", cnt, 32'd25);
    b0 = beats;
    start_drain();
    wait_idle();
    chk("t3_beats", beats - b0, 32'd25);
    chk("t3_q", sb_q.size(), 32'd0);

    // 4: re-drain with backpressure on beat 3
    out_ready = 1'b0;
    b0 = beats;
    start_drain();
    for (int i = 0; i < 25; i++) begin
      wait_valid(ok);
      if (!ok) begin
        chk("t4_valid_timeout", 32'd0, 32'd1);
        break;
      end
      if (i == 2) begin
        hd = out_data;
        hl = out_last;
        for (int j = 0; j < 5; j++) begin
          tick();
          chk("t4_hold_valid", 32'(out_valid), 32'd1);
          chk("t4_hold_data", 32'(out_data), 32'(hd));
          chk("t4_hold_last", 32'(out_last), 32'(hl));
        end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    out_ready = 1'b1;
    wait_idle();
    chk("t4_beats", beats - b0, 32'd25);

    // 5a: 26th store overflows, drain still 25 beats
    chk("t5_ovf_pre", 32'(overflow), 32'd0);
    store(16'd9, 20'h00009, 1'b0);
    chk("t5_ovf", 32'(overflow), 32'(exp_ovf));
    b0 = beats;
    start_drain();
    wait_idle();
    chk("t5_beats", beats - b0, 32'd25);
    do_reset();

    // 5b: extremes and store while busy
    store(16'hFFFF, 20'h65535, 1'b0);
    store(16'h0000, 20'h00000, 1'b0);
    out_ready = 1'b0;
    b0 = beats;
    start_drain();
    wait_valid(ok);
    store_num = 1'b1;
    tick();
    store_num = 1'b0;
    chk("t5_busy_ovf", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    wait_idle();
    start_drain();
    wait_idle();
    chk("t5b_beats", beats - b0, 32'd4);
    do_reset();

    // 6: empty drain, then reset mid-drain
    write_file = 1'b1;
    tick();
    write_file = 1'b0;
    repeat (4) tick();
    chk("t6_empty_busy", 32'(busy), 32'd0);
    chk("t6_empty_valid", 32'(out_valid), 32'd0);
    for (int k = 0; k < 12; k++)
      store(16'(k * 100 + 3), bcd_ref(k * 100 + 3), 1'b0);
    b0 = beats;
    start_drain();
    for (int i = 0; i < 200; i++) begin
      if (out_valid && (beats - b0 == 9)) break;
      tick();
    end
    chk("t6_at_beat10", beats - b0, 32'd9);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    sb_q.delete();
    exp_wr = 0;
    #1;
    rst = 1'b0;
    b0 = beats;
    repeat (20) tick();
    chk("t6_no_beats", beats - b0, 32'd0);
    chk("t6_valid_after", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
